// File: rtl/ysyx_22041752_mul_ctrl_if.sv
// ysyx_22041752_mul_ctrl_if: request/response handshake between execute stage and multiply sequencer
interface ysyx_22041752_mul_ctrl_if #(parameter int DATA_WD = 64);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [DATA_WD-1:0] req_src1;
  logic [DATA_WD-1:0] req_src2;
  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_WD-1:0] resp_data;
  modport master (output req_valid, req_op, req_src1, req_src2, resp_ready,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_op, req_src1, req_src2, resp_ready,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/ysyx_22041752_mul_ctrl.sv
// ysyx_22041752_mul_ctrl: sequences RV64M multiplies through the iterative multiplier with a repeat-result cache
module ysyx_22041752_mul_ctrl #(
  parameter int DATA_WD  = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  ysyx_22041752_mul_ctrl_if.slave bus,
  output logic               busy,
  output logic               mul_valid,
  output logic               mul_u,
  output logic               mul_su,
  output logic               mul_h,
  output logic               mul_flush,
  output logic [DATA_WD-1:0] mul_multiplicand,
  output logic [DATA_WD-1:0] mul_multiplier,
  input  logic [DATA_WD-1:0] mul_product,
  input  logic               mul_out_valid
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2:0] op, c_op;
  logic [DATA_WD-1:0] src1, src2, c_src1, c_src2, c_data, prod, ext1, ext2;
  logic c_vld, accept, hit, rsv, fin, is_w;
  assign bus.req_ready  = ~flush & (state == IDLE | (state == DONE & bus.resp_ready));
  assign bus.resp_valid = state == DONE;
  assign accept    = bus.req_valid & bus.req_ready;
  assign hit       = CACHE_EN && c_vld && c_op == bus.req_op && c_src1 == bus.req_src1 && c_src2 == bus.req_src2;
  assign rsv       = bus.req_op > 3'd4;
  assign is_w      = bus.req_op == 3'd4;
  assign ext1      = is_w ? {{(DATA_WD-32){bus.req_src1[31]}}, bus.req_src1[31:0]} : bus.req_src1;
  assign ext2      = is_w ? {{(DATA_WD-32){bus.req_src2[31]}}, bus.req_src2[31:0]} : bus.req_src2;
  assign prod      = op == 3'd4 ? {{(DATA_WD-32){mul_product[31]}}, mul_product[31:0]} : mul_product;
  // flush in the same cycle as out_valid discards the product
  assign fin       = state == BUSY & mul_out_valid & ~flush;
  assign mul_valid = state == BUSY & ~flush;
  assign mul_flush = state == BUSY & flush;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      op               <= '0;
      src1             <= '0;
      src2             <= '0;
      mul_u            <= 1'b0;
      mul_su           <= 1'b0;
      mul_h            <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      bus.resp_data    <= '0;
      c_vld            <= 1'b0;
      c_op             <= '0;
      c_src1           <= '0;
      c_src2           <= '0;
      c_data           <= '0;
    end else if (accept) begin
      op               <= bus.req_op;
      src1             <= bus.req_src1;
      src2             <= bus.req_src2;
      mul_u            <= bus.req_op == 3'd3;
      mul_su           <= bus.req_op == 3'd2;
      mul_h            <= bus.req_op inside {3'd1, 3'd2, 3'd3};
      mul_multiplicand <= ext1;
      mul_multiplier   <= ext2;
      state            <= hit | rsv ? DONE : BUSY;
      if (hit | rsv) bus.resp_data <= hit ? c_data : '0;
    end else if (fin) begin
      state         <= DONE;
      bus.resp_data <= prod;
      c_vld         <= 1'b1;
      c_op          <= op;
      c_src1        <= src1;
      c_src2        <= src2;
      c_data        <= prod;
    end else if ((state == BUSY & flush) | (state == DONE & (flush | bus.resp_ready))) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ysyx_22041752_mul_ctrl.sv
// tb_ysyx_22041752_mul_ctrl: directed and random checks of the multiply sequencer against a transaction-level model
module tb_ysyx_22041752_mul_ctrl;
  logic clk = 1'b0;
  logic reset, flush;
  logic busy, mul_valid, mul_u, mul_su, mul_h, mul_flush, mul_out_valid;
  logic [63:0] mul_multiplicand, mul_multiplier, mul_product;
  logic [127:0] ma, mb, mp;
  logic [6:0] cnt = '0;
  int checks = 0, failures = 0;
  bit c_vld = 1'b0;
  logic [2:0] c_op = '0;
  logic [63:0] c_a = '0, c_b = '0;
  ysyx_22041752_mul_ctrl_if #(.DATA_WD(64)) bus();
  ysyx_22041752_mul_ctrl #(.DATA_WD(64), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .busy(busy),
    .mul_valid(mul_valid), .mul_u(mul_u), .mul_su(mul_su), .mul_h(mul_h), .mul_flush(mul_flush),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_out_valid(mul_out_valid));
  always #5 clk = ~clk;
  // iterative multiplier stand-in: 66-step count, early finish on a zero operand
  always_ff @(posedge clk) cnt <= mul_valid ? cnt + 7'd1 : 7'd0;
  always_comb begin
    ma = mul_u ? {64'b0, mul_multiplicand} : {{64{mul_multiplicand[63]}}, mul_multiplicand};
    mb = (mul_u | mul_su) ? {64'b0, mul_multiplier} : {{64{mul_multiplier[63]}}, mul_multiplier};
    mp = ma * mb;
    mul_product = mul_h ? mp[127:64] : mp[63:0];
    mul_out_valid = mul_valid & (cnt == 7'd65 | mul_multiplicand == 64'd0 | mul_multiplier == 64'd0);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int w;
    logic signed [127:0] ss;
    logic [127:0] uu, su;
    sa = a;
    sb = b;
    ss = 128'(sa) * 128'(sb);
    uu = {64'b0, a} * {64'b0, b};
    su = 128'(sa) * {64'b0, b};
    w  = int'(a[31:0]) * int'(b[31:0]);
    case (op)
      3'd0:    return uu[63:0];
      3'd1:    return ss[127:64];
      3'd2:    return su[127:64];
      3'd3:    return uu[127:64];
      3'd4:    return 64'(longint'(w));
      default: return 64'd0;
    endcase
  endfunction
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_src1 = a;
    bus.req_src2 = b;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic txn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input bit rr);
    int lat = 1, mv = 0, exp_lat;
    bit z, hit;
    z = op == 3'd4 ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
    hit = c_vld && c_op == op && c_a == a && c_b == b;
    exp_lat = (hit || op > 3'd4) ? 1 : z ? 2 : 67;
    bus.resp_ready = rr;
    issue(op, a, b);
    while (!bus.resp_valid && lat < 100) begin
      mv += int'(mul_valid);
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_data", bus.resp_data, exp);
    chk("mul_valid_cycles", 64'(mv), exp_lat == 67 ? 64'd66 : exp_lat == 2 ? 64'd1 : 64'd0);
    if (!rr) begin
      @(posedge clk);
      #1 chk("resp_hold", {63'd0, bus.resp_valid}, 64'd1);
      chk("resp_hold_data", bus.resp_data, exp);
      @(negedge clk) bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("idle_after_resp", {63'd0, busy}, 64'd0);
    if (exp_lat > 1) begin
      c_vld = 1'b1;
      c_op = op;
      c_a = a;
      c_b = b;
    end
  endtask
  initial begin
    logic [2:0] op;
    logic [63:0] a, b;
    reset = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    @(negedge clk) reset = 1'b1;
    #1 chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    txn(3'd0, 64'd3, 64'd5, 64'd15, 1'b0);
    txn(3'd0, 64'd3, 64'd5, 64'd15, 1'b1);
    txn(3'd0, 64'd3, 64'd6, 64'd18, 1'b0);
    txn(3'd1, '1, '1, 64'd0, 1'b0);
    txn(3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    txn(3'd2, '1, 64'd2, '1, 1'b0);
    txn(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    txn(3'd0, 64'd5, 64'd0, 64'd0, 1'b0);
    txn(3'd6, 64'd3, 64'd5, 64'd0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    flush = 1'b1;
    #1 chk("idle_flush_ready", {63'd0, bus.req_ready}, 64'd0);
    @(posedge clk);
    #1 chk("idle_flush_busy", {63'd0, busy}, 64'd0);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    issue(3'd0, 64'd11, 64'd13);
    repeat (29) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    #1 chk("flush_mul_flush", {63'd0, mul_flush}, 64'd1);
    chk("flush_mul_valid", {63'd0, mul_valid}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_mul_flush_drop", {63'd0, mul_flush}, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("flush_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    txn(3'd0, 64'd7, 64'd9, 64'd63, 1'b0);
    issue(3'd1, 64'd123, 64'd456);
    repeat (20) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("arst_mcand", mul_multiplicand, 64'd0);
    chk("arst_mplier", mul_multiplier, 64'd0);
    chk("arst_mul_h", {63'd0, mul_h}, 64'd0);
    c_vld = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    txn(3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0 && c_vld) begin
        op = c_op;
        a = c_a;
        b = c_b;
      end else begin
        op = 3'($urandom_range(0, 7));
        a = $urandom_range(0, 7) == 0 ? 64'd0 : {$urandom, $urandom};
        b = $urandom_range(0, 7) == 0 ? 64'd0 : {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a[31:0] = 32'd0;
      end
      txn(op, a, b, ref_mul(op, a, b), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
